// File: rtl/axis_len_to_keep_framer_pkg.sv
// Shared definitions for the length-to-keep framer and the keep-to-count path:
// FSM state encoding, beat-size derivation and count-width helper.
package axis_len_to_keep_framer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 256;

    function automatic int unsigned bytes_per_beat(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Bits needed to hold a byte count of 0..n inclusive.
    function automatic int unsigned count_bits(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned COUNT_BITS = count_bits(bytes_per_beat(DEFAULT_DATA_WIDTH));

endpackage

// File: rtl/axis_len_to_keep_framer_count_to_keep_mask.sv
// Combinational thermometer mask: a count of N (0..INPUT_SIZE) sets the low N bits.
// Inverse of the last-bit count used on the receive side.
module count_to_keep_mask
    import axis_len_to_keep_framer_pkg::*;
#(
    parameter int unsigned INPUT_SIZE = 32
) (
    input  logic [count_bits(INPUT_SIZE)-1:0] count,
    output logic [INPUT_SIZE-1:0]             mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(INPUT_SIZE); i++) begin
            mask[i] = (i < int'(count));
        end
    end

endmodule

// File: rtl/axis_len_to_keep_framer.sv
// Frames an unframed payload word stream into AXI-Stream beats using a byte-length command.
// Build option: AXIS_FRAMER_ZERO_PAD_EN zeroes the unused bytes of the last beat.
//
// state  | meaning
// IDLE   | waiting for a length command; no output beats, payload not consumed
// STREAM | passing payload words through, counting down remaining bytes
module axis_len_to_keep_framer
    import axis_len_to_keep_framer_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH = 256,
    parameter int unsigned LEN_WIDTH           = 16
) (
    input  logic                               axis_aclk,
    input  logic                               axis_resetn,
    input  logic                               cmd_tvalid,
    output logic                               cmd_tready,
    input  logic [LEN_WIDTH-1:0]               cmd_len,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]     s_data_tdata,
    input  logic                               s_data_tvalid,
    output logic                               s_data_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast
);

    localparam int unsigned         BYTES_PER_BEAT = bytes_per_beat(C_M_AXIS_DATA_WIDTH);
    localparam int unsigned         CNT_W          = count_bits(BYTES_PER_BEAT);
    localparam logic [LEN_WIDTH-1:0] BEAT_LEN      = LEN_WIDTH'(BYTES_PER_BEAT);

    state_t                    state;
    state_t                    state_next;
    logic [LEN_WIDTH-1:0]      rem_bytes;
    logic [LEN_WIDTH-1:0]      rem_next;
    logic                      last;
    logic [CNT_W-1:0]          last_count;
    logic [BYTES_PER_BEAT-1:0] last_mask;

    assign last       = (rem_bytes <= BEAT_LEN);
    // Only meaningful when last is set, where rem_bytes fits in CNT_W bits.
    assign last_count = rem_bytes[CNT_W-1:0];

    count_to_keep_mask #(
        .INPUT_SIZE(BYTES_PER_BEAT)
    ) u_last_mask (
        .count(last_count),
        .mask (last_mask)
    );

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state     <= IDLE;
            rem_bytes <= '0;
        end else begin
            state     <= state_next;
            rem_bytes <= rem_next;
        end
    end

    always_comb begin
        state_next    = state;
        rem_next      = rem_bytes;
        cmd_tready    = 1'b0;
        s_data_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = '0;
        case (state)
            IDLE: begin
                cmd_tready = 1'b1;
                if (cmd_tvalid && (cmd_len != '0)) begin
                    state_next = STREAM;
                    rem_next   = cmd_len;
                end
            end
            STREAM: begin
                m_axis_tvalid = s_data_tvalid;
                s_data_tready = m_axis_tready;
                if (last) begin
                    m_axis_tlast = 1'b1;
                    m_axis_tkeep = last_mask;
                    if (s_data_tvalid && m_axis_tready) begin
                        state_next = IDLE;
                        rem_next   = '0;
                    end
                end else begin
                    m_axis_tkeep = '1;
                    if (s_data_tvalid && m_axis_tready) begin
                        rem_next = rem_bytes - BEAT_LEN;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef AXIS_FRAMER_ZERO_PAD_EN
    for (genvar b = 0; b < int'(BYTES_PER_BEAT); b++) begin : g_pad
        assign m_axis_tdata[b*8 +: 8] = ((state == STREAM) && last && !last_mask[b])
                                        ? 8'h00 : s_data_tdata[b*8 +: 8];
    end
`else
    assign m_axis_tdata = s_data_tdata;
`endif

endmodule

// File: tb/tb_axis_len_to_keep_framer.sv
// Scoreboard bench for axis_len_to_keep_framer: directed cases plus randomized packets
// checked against a per-packet byte-count model.
module tb_axis_len_to_keep_framer;

    localparam int DW = 256;
    localparam int B  = DW / 8;
    localparam int LW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [B-1:0]  keep;
        logic          last;
    } beat_t;

    logic          axis_aclk;
    logic          axis_resetn;
    logic          cmd_tvalid;
    logic          cmd_tready;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] s_data_tdata;
    logic          s_data_tvalid;
    logic          s_data_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [B-1:0]  m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    beat_t         exp_q[$];
    logic [DW-1:0] data_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            rdy_mode = 0;
    logic          rdy_manual = 1'b0;
    bit            data_always = 1'b1;

    axis_len_to_keep_framer #(
        .C_M_AXIS_DATA_WIDTH(DW),
        .LEN_WIDTH          (LW)
    ) dut (
        .axis_aclk    (axis_aclk),
        .axis_resetn  (axis_resetn),
        .cmd_tvalid   (cmd_tvalid),
        .cmd_tready   (cmd_tready),
        .cmd_len      (cmd_len),
        .s_data_tdata (s_data_tdata),
        .s_data_tvalid(s_data_tvalid),
        .s_data_tready(s_data_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Payload source and downstream ready generator; decisions made on the negedge sample.
    initial begin
        bit took;
        s_data_tvalid = 1'b0;
        s_data_tdata  = '0;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge axis_aclk);
            took = s_data_tvalid && s_data_tready && axis_resetn;
            @(posedge axis_aclk);
            #1;
            if (took && data_q.size() > 0) void'(data_q.pop_front());
            if (data_q.size() == 0) begin
                s_data_tvalid = 1'b0;
            end else begin
                if (took || !s_data_tvalid)
                    s_data_tvalid = data_always || ($urandom_range(0, 3) != 0);
                s_data_tdata = data_q[0];
            end
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = rdy_manual;
            endcase
        end
    end

    // Monitor: pops expected beats on every output transfer.
    initial begin
        beat_t       e;
        bit          stall_prev = 1'b0;
        bit          idle_due = 1'b0;
        logic [B-1:0] hold_keep = '0;
        logic        hold_last = 1'b0;
        forever begin
            @(negedge axis_aclk);
            if (axis_resetn) begin
                if (idle_due) begin
                    check("gap_cmd_tready", DW'(cmd_tready), DW'(1));
                    check("gap_tvalid", DW'(m_axis_tvalid), DW'(0));
                    idle_due = 1'b0;
                end
                if (stall_prev && m_axis_tvalid) begin
                    check("stall_keep_hold", DW'(m_axis_tkeep), DW'(hold_keep));
                    check("stall_last_hold", DW'(m_axis_tlast), DW'(hold_last));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got keep %h last %0d expected no beat",
                                 m_axis_tkeep, m_axis_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_axis_tdata, e.data);
                        check("beat_keep", DW'(m_axis_tkeep), DW'(e.keep));
                        check("beat_last", DW'(m_axis_tlast), DW'(e.last));
                        idle_due = e.last;
                    end
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                hold_keep  = m_axis_tkeep;
                hold_last  = m_axis_tlast;
            end else begin
                stall_prev = 1'b0;
                idle_due   = 1'b0;
            end
        end
    end

    // Model: a packet of len bytes is ceil(len/B) beats; beat i carries min(B, len-i*B) bytes.
    task automatic send_cmd(input int len);
        int    beats;
        int    nb;
        bit    ok;
        beat_t bt;
        logic [DW-1:0] word;
        beats = (len + B - 1) / B;
        for (int i = 0; i < beats; i++) begin
            word = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            nb = (len - i * B > B) ? B : (len - i * B);
            bt.keep = '0;
            for (int k = 0; k < nb; k++) bt.keep[k] = 1'b1;
            bt.last = (i == beats - 1);
            bt.data = word;
`ifdef AXIS_FRAMER_ZERO_PAD_EN
            if (bt.last)
                for (int k = nb; k < B; k++) bt.data[k*8 +: 8] = 8'h00;
`endif
            data_q.push_back(word);
            exp_q.push_back(bt);
        end
        @(posedge axis_aclk);
        #1;
        cmd_tvalid = 1'b1;
        cmd_len    = LW'(len);
        ok = 1'b0;
        for (int c = 0; c < 5000 && !ok; c++) begin
            @(negedge axis_aclk);
            if (cmd_tready && axis_resetn) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_timeout: got no cmd_tready expected accept of len %0d", len);
        end
        @(posedge axis_aclk);
        #1;
        cmd_tvalid = 1'b0;
        if (ok && len == 0) begin
            @(negedge axis_aclk);
            check("zero_len_cmd_tready", DW'(cmd_tready), DW'(1));
            check("zero_len_tvalid", DW'(m_axis_tvalid), DW'(0));
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(negedge axis_aclk);
        check("drain_pending_beats", DW'(exp_q.size()), DW'(0));
        repeat (2) @(negedge axis_aclk);
    endtask

    initial begin
        axis_resetn = 1'b0;
        cmd_tvalid  = 1'b0;
        cmd_len     = '0;
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("rst_s_tready", DW'(s_data_tready), DW'(0));
        check("rst_tlast", DW'(m_axis_tlast), DW'(0));
        check("rst_tkeep", DW'(m_axis_tkeep), DW'(0));
        check("rst_cmd_tready", DW'(cmd_tready), DW'(1));
        axis_resetn = 1'b1;

        rdy_mode = 0;
        data_always = 1'b1;
        send_cmd(64);  wait_drain();
        send_cmd(70);  wait_drain();
        send_cmd(1);   wait_drain();
        send_cmd(0);   wait_drain();
        send_cmd(32);  wait_drain();
        rdy_mode = 1;
        send_cmd(100); wait_drain();

        // Reset during beat 2 of a 100-byte packet.
        rdy_mode = 3;
        rdy_manual = 1'b0;
        send_cmd(100);
        @(negedge axis_aclk) rdy_manual = 1'b1;
        @(negedge axis_aclk) rdy_manual = 1'b0;
        @(posedge axis_aclk);
        #1;
        axis_resetn = 1'b0;
        @(negedge axis_aclk);
        check("beats_before_reset", DW'(exp_q.size()), DW'(3));
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("post_reset_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("post_reset_cmd_tready", DW'(cmd_tready), DW'(1));
        exp_q.delete();
        data_q.delete();
        axis_resetn = 1'b1;
        rdy_mode = 0;
        send_cmd(33);  wait_drain();

        for (int p = 0; p < 40; p++) begin
            rdy_mode    = $urandom_range(0, 2);
            data_always = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) send_cmd(B * $urandom_range(0, 5));
            else                           send_cmd($urandom_range(0, 200));
        end
        rdy_mode = 0;
        wait_drain();
        check("leftover_payload_words", DW'(data_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_len_to_keep_framer.md
Name: axis_len_to_keep_framer

Overview:
Transmit-side counterpart of the keep-to-count path. It takes a byte-length command and an unframed data-word stream, and emits AXI-Stream beats with tkeep and tlast derived from the remaining byte count. It sits in the output path ahead of the MAC/port interface, where payloads are built from a length and need a framed stream. It tracks remaining bytes per packet with a small FSM.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, data bus width in bits; must be a multiple of 8.
LEN_WIDTH, 16, width of the byte-length command.
BYTES_PER_BEAT, C_M_AXIS_DATA_WIDTH/8, derived localparam; not overridable.

Ports:
axis_aclk  in  1  single clock for all logic.
axis_resetn  in  1  reset; synchronous, active-low.
cmd_tvalid  in  1  length command valid.
cmd_tready  out  1  length command accepted.
cmd_len  in  LEN_WIDTH  packet length in bytes.
s_data_tdata  in  C_M_AXIS_DATA_WIDTH  raw payload word; byte 0 is in bits [7:0].
s_data_tvalid  in  1  payload word valid.
s_data_tready  out  1  payload word accepted.
m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  framed data.
m_axis_tkeep  out  BYTES_PER_BEAT  byte enables.
m_axis_tvalid  out  1  output beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  last beat of packet.

Behaviour:
- States: IDLE and STREAM. The state register resets to IDLE and rem_bytes (LEN_WIDTH bits) resets to 0.
- All outputs are combinational from the state, rem_bytes and the inputs. In IDLE (and therefore immediately after reset): m_axis_tvalid=0, s_data_tready=0, m_axis_tlast=0, m_axis_tkeep=0, cmd_tready=1.
- IDLE, cmd_tvalid=1, cmd_len!=0: accept the command, load rem_bytes=cmd_len, go to STREAM.
- IDLE, cmd_tvalid=1, cmd_len=0: accept the command, emit nothing, stay in IDLE.
- STREAM: cmd_tready=0. m_axis_tvalid=s_data_tvalid, s_data_tready=m_axis_tready, m_axis_tdata=s_data_tdata. Zero added latency and no buffering.
- Define last = (rem_bytes <= BYTES_PER_BEAT).
- Non-last beat: m_axis_tkeep all ones, m_axis_tlast=0. On transfer (tvalid & tready), rem_bytes -= BYTES_PER_BEAT.
- Last beat: m_axis_tlast=1 and m_axis_tkeep = mask of the low rem_bytes bits set (rem_bytes=BYTES_PER_BEAT gives all ones). On transfer, go to IDLE and clear rem_bytes.
- Beat count is ceil(cmd_len/BYTES_PER_BEAT). The subtraction never underflows because the last beat is handled separately.
- One IDLE cycle always separates packets; a command presented during STREAM waits.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, tkeep and tlast stay stable, since rem_bytes only changes on transfer. Data stability is the upstream's obligation.
- Extra payload words beyond the packet are not consumed while in IDLE.
- Reset mid-packet: the next cycle is in IDLE. The partial packet is abandoned with no tlast emitted.

Optional Feature:
AXIS_FRAMER_ZERO_PAD_EN.
- Defined: on the last beat, m_axis_tdata bytes whose tkeep bit is 0 are driven to 0x00.
- Undefined: tdata passes through unmodified on every beat.
- tkeep, tlast and timing are identical in both builds.

Decomposition:
- Shared package/include holds:
  - state encoding constants (IDLE=1'b0, STREAM=1'b1);
  - the BYTES_PER_BEAT derivation;
  - a $clog2-based COUNT_BITS constant, shared with the keep-to-count path.
- One natural sub-module: count_to_keep_mask, parameterized by INPUT_SIZE.
  - Purely combinational; maps a 1-based count in 0..INPUT_SIZE to a thermometer mask.
  - This is the inverse of the existing last-bit count.
  - Reuse it in the FSM and in the zero-pad logic.

Test Plan:
1. 256-bit bus, cmd_len=64, always ready -> 2 beats, both tkeep=0xFFFFFFFF, tlast only on beat 2; cmd_tready=1 the cycle after.
2. cmd_len=70 -> 3 beats; beat 3 has tkeep=0x0000003F and tlast=1.
3. cmd_len=1 -> 1 beat, tkeep=0x00000001, tlast=1. With AXIS_FRAMER_ZERO_PAD_EN, tdata[255:8]=0.
4. cmd_len=0 -> command consumed in 1 cycle, no m_axis_tvalid; a following cmd_len=32 gives 1 full beat with tlast.
5. cmd_len=100 with m_axis_tready toggling 1010… -> 4 beats (keep on the last beat = 0x0000000F); tkeep and tlast are held while stalled and each s_data word is consumed exactly once.
6. cmd_len=100, axis_resetn=0 during beat 2 -> next cycle m_axis_tvalid=0 and cmd_tready=1; a new cmd_len=33 then yields 2 beats with last tkeep=0x00000001.
